// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
//   Shared types and helpers for the single-port RAM initiator slice.
//   - state_t      : initiator FSM encoding (ST_INIT sweep, ST_RUN traffic)
//   - RSP_DEPTH    : response buffer depth (one buffered + one in flight)
//   - bw_of()      : byte-enable width for a given data width
// ---------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [1:0] RSP_DEPTH = 2'd2;

    function automatic int bw_of(input int dw);
        return (dw + 7) / 8;
    endfunction

endpackage

// File: rtl/sp_ram_rsp_fifo.sv
// ---------------------------------------------------------------------------
// sp_ram_rsp_fifo
//   2-entry shift-style FIFO for RAM read data. Entry 0 is always the head,
//   so pop_data is a plain register output and keeps the last value when
//   the FIFO drains.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_data (ignored when full and not popping)
//   push_data    DW-bit data in
//   pop          consume head (ignored when empty)
//   pop_data     head entry
//   full, empty  occupancy flags
// ---------------------------------------------------------------------------
module sp_ram_rsp_fifo
    import mem_pkg::*;
#(
    parameter int DW = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty
);

    logic [1:0][DW-1:0] entry;
    logic [1:0]         count;
    logic               do_pop;
    logic               do_push;

    assign empty    = (count == 2'd0);
    assign full     = (count == RSP_DEPTH);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = entry[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry <= '0;
            count <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) entry[0] <= push_data;
                    else               entry[1] <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    // Going 1 -> 0 leaves entry 0 untouched so the output holds.
                    if (count == RSP_DEPTH) entry[0] <= entry[1];
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        entry[0] <= push_data;
                    end else begin
                        entry[0] <= entry[1];
                        entry[1] <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sp_ram_initiator.sv
// ---------------------------------------------------------------------------
// sp_ram_initiator
//   Request-side master for a single-port RAM with 1-cycle read latency.
//   Clears the array to INIT_VALUE after reset, then turns a valid/ready
//   request stream into RAM en/we/addr/din and returns read data on a
//   valid/ready response stream through a 2-entry buffer.
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_we/req_addr/req_wdata  byte enables (all-zero = read), address, data
//   rsp_valid/rsp_ready        read response handshake
//   rsp_rdata                  read data
//   init_busy                  clear sweep in progress
//   mem_en/we/addr/din         RAM port
//   mem_dout                   RAM read data, valid the cycle after a read
// ---------------------------------------------------------------------------
module sp_ram_initiator
    import mem_pkg::*;
#(
    parameter int                       MEM_DATAWIDTH = 128,
    parameter int                       MEM_ADDRWIDTH = 14,
    parameter bit                       INIT_ON_RESET = 1'b1,
    parameter logic [MEM_DATAWIDTH-1:0] INIT_VALUE    = '0,
    localparam int                      BW            = bw_of(MEM_DATAWIDTH)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [BW-1:0]            req_we,
    input  logic [MEM_ADDRWIDTH-1:0] req_addr,
    input  logic [MEM_DATAWIDTH-1:0] req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [MEM_DATAWIDTH-1:0] rsp_rdata,
    output logic                     init_busy,
    output logic                     mem_en,
    output logic [BW-1:0]            mem_we,
    output logic [MEM_ADDRWIDTH-1:0] mem_addr,
    output logic [MEM_DATAWIDTH-1:0] mem_din,
    input  logic [MEM_DATAWIDTH-1:0] mem_dout
);

    localparam state_t RESET_STATE = INIT_ON_RESET ? ST_INIT : ST_RUN;

    state_t                   state;
    state_t                   state_nxt;
    logic [MEM_ADDRWIDTH-1:0] sweep_addr;
    logic                     inflight;
    logic                     fire;
    logic                     rd_fire;
    logic                     pop;
    logic                     full;
    logic                     empty;
    logic [1:0]               cnt;

    assign rsp_valid = !empty;
    assign pop       = rsp_valid && rsp_ready;
    assign init_busy = (state == ST_INIT);
    // Credit = buffered responses + read whose data is still on mem_dout.
    assign cnt       = (full ? 2'd2 : {1'b0, !empty}) + {1'b0, inflight};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RESET_STATE;
            sweep_addr <= '0;
            inflight   <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= rd_fire;
            if (state == ST_INIT) sweep_addr <= sweep_addr + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        fire      = 1'b0;
        rd_fire   = 1'b0;
        mem_en    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_din   = '0;
        // Outputs are forced quiet while reset is held: the FSM already sits
        // in INIT then, and the RAM must not see sweep writes during reset.
        if (reset_n) begin
            case (state)
                ST_INIT: begin
                    mem_en   = 1'b1;
                    mem_we   = '1;
                    mem_addr = sweep_addr;
                    mem_din  = INIT_VALUE;
                    if (sweep_addr == '1) state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    // A pop this cycle frees a slot in time for a new read.
                    req_ready = (cnt < RSP_DEPTH) || pop;
                    fire      = req_valid && req_ready;
                    rd_fire   = fire && (req_we == '0);
                    mem_en    = fire;
                    mem_we    = fire ? req_we : '0;
                    mem_addr  = req_addr;
                    mem_din   = req_wdata;
                end
                default: state_nxt = RESET_STATE;
            endcase
        end
    end

    sp_ram_rsp_fifo #(
        .DW (MEM_DATAWIDTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (reset_n),
        .push      (inflight),
        .push_data (mem_dout),
        .pop       (pop),
        .pop_data  (rsp_rdata),
        .full      (full),
        .empty     (empty)
    );

endmodule

// File: tb/tb_sp_ram_initiator.sv
// Bench for sp_ram_initiator paired with a behavioural read-first RAM.
// A reference memory tracks accepted writes; each accepted read pushes its
// expected data, popped and compared when a response handshake happens.
module tb_sp_ram_initiator;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int BW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [BW-1:0] req_we = '0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          init_busy;
    logic          mem_en;
    logic [BW-1:0] mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout = '0;

    always #5 clk = ~clk;

    sp_ram_initiator #(
        .MEM_DATAWIDTH (DW),
        .MEM_ADDRWIDTH (AW),
        .INIT_ON_RESET (1'b1),
        .INIT_VALUE    (32'h0)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .init_busy (init_busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    // RAM macro model: read-first, byte enables, registered dout.
    // Starts filled with a non-zero pattern so the clear sweep is observable.
    logic [DW-1:0] ram [DEPTH];
    logic          ram_filled = 1'b0;

    always @(posedge clk) begin
        if (!ram_filled) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= 32'hA5A5_A5A5;
            ram_filled <= 1'b1;
        end else if (mem_en) begin
            if (mem_we == '0) mem_dout <= ram[mem_addr];
            for (int b = 0; b < BW; b++)
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
        end
    end

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    int            checks = 0;
    int            fails  = 0;
    logic          acc;
    logic [DW-1:0] last_rdata;
    logic          s_req_ready, s_rsp_valid, s_init_busy, s_mem_en;
    logic [BW-1:0] s_mem_we;
    logic [AW-1:0] s_mem_addr;
    logic [DW-1:0] s_mem_din, s_rsp_rdata;

    // One clock: sample at the falling edge (handshakes, scoreboard), then
    // return just after the next rising edge so callers can drive inputs.
    task automatic cycle();
        logic [DW-1:0] exp;
        @(negedge clk);
        s_req_ready = req_ready;
        s_rsp_valid = rsp_valid;
        s_rsp_rdata = rsp_rdata;
        s_init_busy = init_busy;
        s_mem_en    = mem_en;
        s_mem_we    = mem_we;
        s_mem_addr  = mem_addr;
        s_mem_din   = mem_din;
        acc = req_valid && req_ready;
        if (acc) begin
            if (req_we == '0) exp_q.push_back(ref_mem[req_addr]);
            else
                for (int b = 0; b < BW; b++)
                    if (req_we[b]) ref_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
        end
        if (rsp_valid && rsp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: got response %h, expected none", rsp_rdata);
            end else begin
                exp = exp_q.pop_front();
                if (rsp_rdata !== exp) begin
                    fails++;
                    $display("FAIL sb_rdata: got %h, expected %h", rsp_rdata, exp);
                end
            end
            last_rdata = rsp_rdata;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [BW-1:0] we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, output int tries);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        tries     = 0;
        do begin
            cycle();
            tries++;
        end while (!acc && tries < 50);
        if (!acc) begin
            checks++;
            fails++;
            $display("FAIL req_timeout: addr %0d not accepted after %0d cycles, expected acceptance", addr, tries);
        end
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_we    = '0;
    endtask

    task automatic drain();
        int n = 0;
        rsp_ready = 1'b1;
        while (exp_q.size() != 0 && n < 50) begin
            cycle();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
        end
        cycle();
        checks++;
        if (s_rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL drain_idle: rsp_valid %b, expected 0", s_rsp_valid);
        end
    endtask

    // Reset released just before the call: 16 sweep writes then RUN.
    task automatic test_sweep();
        for (int i = 0; i < DEPTH; i++) begin
            cycle();
            checks++;
            if ({s_init_busy, s_mem_en, s_mem_we, s_mem_addr, s_req_ready, s_mem_din} !==
                {1'b1, 1'b1, 4'hF, 4'(i), 1'b0, 32'h0}) begin
                fails++;
                $display("FAIL sweep_%0d: busy %b en %b we %h addr %0d ready %b din %h, expected 1 1 f %0d 0 0",
                         i, s_init_busy, s_mem_en, s_mem_we, s_mem_addr, s_req_ready, s_mem_din, i);
            end
        end
        cycle();
        checks++;
        if ({s_init_busy, s_req_ready} !== 2'b01) begin
            fails++;
            $display("FAIL sweep_done: busy %b ready %b, expected 0 1", s_init_busy, s_req_ready);
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cycle();
        cycle();
        checks++;
        if ({s_req_ready, s_rsp_valid, s_mem_en, s_init_busy} !== 4'b0001) begin
            fails++;
            $display("FAIL reset_ctrl: ready %b rsp_valid %b en %b busy %b, expected 0 0 0 1",
                     s_req_ready, s_rsp_valid, s_mem_en, s_init_busy);
        end
        checks++;
        if ({s_mem_we, s_mem_addr, s_mem_din, s_rsp_rdata} !== '0) begin
            fails++;
            $display("FAIL reset_data: we %h addr %h din %h rdata %h, expected all 0",
                     s_mem_we, s_mem_addr, s_mem_din, s_rsp_rdata);
        end
        reset_n = 1'b1;
        test_sweep();
    endtask

    task automatic test_read_all();
        int t;
        rsp_ready = 1'b1;
        for (int a = 0; a < DEPTH; a++) do_req('0, 4'(a), '0, t);
        idle();
        drain();
    endtask

    task automatic test_write_read();
        int t;
        rsp_ready = 1'b1;
        do_req(4'hF, 4'd3, 32'hDEAD_BEEF, t);
        checks++;
        if ({s_mem_en, s_mem_we, s_mem_addr, s_mem_din} !== {1'b1, 4'hF, 4'd3, 32'hDEAD_BEEF}) begin
            fails++;
            $display("FAIL wr_port: en %b we %h addr %0d din %h, expected 1 f 3 deadbeef",
                     s_mem_en, s_mem_we, s_mem_addr, s_mem_din);
        end
        do_req('0, 4'd3, '0, t);
        idle();
        cycle();
        checks++;
        if ({s_rsp_valid, s_mem_en, s_mem_we} !== 6'b0) begin
            fails++;
            $display("FAIL rd_lat1: rsp_valid %b en %b we %h, expected 0 0 0", s_rsp_valid, s_mem_en, s_mem_we);
        end
        cycle();
        checks++;
        if ({s_rsp_valid, s_rsp_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
            fails++;
            $display("FAIL rd_lat2: rsp_valid %b rdata %h, expected 1 deadbeef", s_rsp_valid, s_rsp_rdata);
        end
        drain();
    endtask

    task automatic test_byte_merge();
        int t;
        do_req(4'b0010, 4'd3, 32'h0000_AB00, t);
        do_req('0, 4'd3, '0, t);
        idle();
        drain();
        checks++;
        if (last_rdata !== 32'hDEAD_ABEF) begin
            fails++;
            $display("FAIL byte_merge: got %h, expected deadabef", last_rdata);
        end
    endtask

    task automatic test_backpressure();
        int t;
        int k = 0;
        int n = 0;
        for (int i = 0; i < 4; i++) do_req(4'hF, 4'(i), 32'h1111_0000 + i, t);
        idle();
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1;
            req_addr  = 4'(k);
            cycle();
            if (acc) k++;
        end
        checks++;
        if (k !== 2) begin
            fails++;
            $display("FAIL bp_accepted: %0d reads accepted, expected 2", k);
        end
        checks++;
        if ({s_req_ready, s_rsp_valid, s_rsp_rdata} !== {1'b0, 1'b1, 32'h1111_0000}) begin
            fails++;
            $display("FAIL bp_stall: ready %b rsp_valid %b rdata %h, expected 0 1 11110000",
                     s_req_ready, s_rsp_valid, s_rsp_rdata);
        end
        rsp_ready = 1'b1;
        while (k < 4 && n < 20) begin
            req_addr = 4'(k);
            cycle();
            if (acc) k++;
            n++;
        end
        idle();
        checks++;
        if (k !== 4) begin
            fails++;
            $display("FAIL bp_release: %0d reads accepted, expected 4", k);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [10:0] vpat;
        int          nacc = 0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            if (i < 8) begin
                req_valid = 1'b1;
                req_we    = '0;
                req_addr  = 4'(i + 8);
            end else begin
                idle();
            end
            cycle();
            vpat[i] = s_rsp_valid;
            if (acc) nacc++;
        end
        checks++;
        if (nacc !== 8) begin
            fails++;
            $display("FAIL b2b_accepted: %0d, expected 8", nacc);
        end
        checks++;
        if (vpat !== 11'b011_1111_1100) begin
            fails++;
            $display("FAIL b2b_pattern: rsp_valid by cycle %b, expected 01111111100", vpat);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int k = 0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_we    = '0;
            req_addr  = 4'(k);
            cycle();
            if (acc) k++;
        end
        idle();
        cycle();
        checks++;
        if (s_rsp_valid !== 1'b1) begin
            fails++;
            $display("FAIL mid_buffered: rsp_valid %b, expected 1", s_rsp_valid);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, req_ready, mem_en, init_busy} !== 4'b0001) begin
            fails++;
            $display("FAIL mid_traffic_reset: rsp_valid %b ready %b en %b busy %b, expected 0 0 0 1",
                     rsp_valid, req_ready, mem_en, init_busy);
        end
        exp_q.delete();
        cycle();
        reset_n = 1'b1;
        for (int i = 0; i < 7; i++) cycle();
        checks++;
        if (mem_addr !== 4'd7) begin
            fails++;
            $display("FAIL mid_sweep_pos: addr %0d, expected 7", mem_addr);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({mem_en, mem_addr, init_busy} !== {1'b0, 4'd0, 1'b1}) begin
            fails++;
            $display("FAIL mid_sweep_reset: en %b addr %0d busy %b, expected 0 0 1", mem_en, mem_addr, init_busy);
        end
        cycle();
        rsp_ready = 1'b1;
        reset_n   = 1'b1;
        test_sweep();
        test_read_all();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        test_reset();
        test_read_all();
        test_write_read();
        test_byte_merge();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
